// File: rtl/dot_product_ctrl.sv
// Batch sequencer for dot products. It reads paired A/B vector elements from a synchronous
// memory, streams operand pairs to a dot-product unit, and hands each result to a writer.
module dot_product_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ADDR_WIDTH   = 6,
    parameter int RESULT_WIDTH = 2*DATA_WIDTH + $clog2(VECTOR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [2:0]              num_jobs,
    input  logic [ADDR_WIDTH-1:0]   base_a,
    input  logic [ADDR_WIDTH-1:0]   base_b,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic                    op_valid,
    output logic [DATA_WIDTH-1:0]   op_a,
    output logic [DATA_WIDTH-1:0]   op_b,
    output logic                    op_last,
    input  logic                    dp_valid,
    input  logic [RESULT_WIDTH-1:0] dp_result,
    output logic                    result_valid,
    output logic [RESULT_WIDTH-1:0] dot_product_result,
    output logic                    processing_done,
    input  logic                    writer_done,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              job_count,
    output logic                    timeout_err
);
    localparam int IDX_W = $clog2(VECTOR_WIDTH);

    typedef enum logic [3:0] {
        IDLE, RD_A, RD_B, OP, WAIT_DP, HANDOFF, FLUSH, WAIT_WR, DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_base_a;
    logic [ADDR_WIDTH-1:0]   r_base_b;
    logic [2:0]              r_num_jobs;
    logic [2:0]              r_job_count;
    logic [IDX_W-1:0]        r_idx;
    logic [3:0]              r_tmo;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic [RESULT_WIDTH-1:0] r_result;
    logic                    r_timeout;

    logic                    w_busy;
    logic                    w_abort;
    logic                    w_last;
    logic                    w_tmo_hit;
    logic [2:0]              w_job_inc;
    logic [ADDR_WIDTH-1:0]   w_off;

    // VECTOR_WIDTH is a power of two, so job*VECTOR_WIDTH+idx is a plain concatenation.
    assign w_off     = ADDR_WIDTH'({r_job_count, r_idx});
    assign w_last    = (r_idx == IDX_W'(VECTOR_WIDTH - 1));
    assign w_busy    = (r_state != IDLE) && (r_state != DONE);
    assign w_abort   = abort && w_busy;
    assign w_tmo_hit = !dp_valid && (r_tmo == 4'd15);
    assign w_job_inc = r_job_count + 3'd1;

    assign busy               = w_busy;
    assign op_a               = r_op_a;
    assign dot_product_result = r_result;
    assign job_count          = r_job_count;
    assign timeout_err        = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        mem_rd_en       = 1'b0;
        mem_rd_addr     = '0;
        op_valid        = 1'b0;
        op_last         = 1'b0;
        op_b            = '0;
        result_valid    = 1'b0;
        processing_done = 1'b0;
        done            = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_next = (num_jobs != 3'd0) ? RD_A : DONE;
            end
            RD_A: begin
                mem_rd_en    = 1'b1;
                mem_rd_addr  = r_base_a + w_off;
                w_state_next = RD_B;
            end
            RD_B: begin
                mem_rd_en    = 1'b1;
                mem_rd_addr  = r_base_b + w_off;
                w_state_next = OP;
            end
            OP: begin
                op_valid     = 1'b1;
                op_b         = mem_rd_data;
                op_last      = w_last;
                w_state_next = w_last ? WAIT_DP : RD_A;
            end
            WAIT_DP: begin
                if (dp_valid)       w_state_next = HANDOFF;
                else if (w_tmo_hit) w_state_next = DONE;
            end
            HANDOFF: begin
                result_valid = 1'b1;
                w_state_next = FLUSH;
            end
            FLUSH: begin
                processing_done = 1'b1;
                w_state_next    = WAIT_WR;
            end
            WAIT_WR: begin
                if (writer_done) w_state_next = (w_job_inc == r_num_jobs) ? DONE : RD_A;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        // Abort outranks any handshake arriving in the same cycle.
        if (w_abort) w_state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base_a    <= '0;
            r_base_b    <= '0;
            r_num_jobs  <= '0;
            r_job_count <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_op_a      <= '0;
            r_result    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (r_state != WAIT_DP) r_tmo <= '0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_base_a    <= base_a;
                        r_base_b    <= base_b;
                        r_num_jobs  <= num_jobs;
                        r_job_count <= '0;
                        r_idx       <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                RD_B: begin
                    if (!w_abort) r_op_a <= mem_rd_data;
                end
                OP: begin
                    if (!w_abort && !w_last) r_idx <= r_idx + IDX_W'(1);
                end
                WAIT_DP: begin
                    if (!w_abort) begin
                        if (dp_valid)       r_result  <= dp_result;
                        else if (w_tmo_hit) r_timeout <= 1'b1;
                        else                r_tmo     <= r_tmo + 4'd1;
                    end
                end
                WAIT_WR: begin
                    if (!w_abort && writer_done) begin
                        r_job_count <= w_job_inc;
                        r_idx       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl: memory, dot-product and writer models plus a
// scoreboard of expected read addresses and results.
`timescale 1ns/1ps
module tb_dot_product_ctrl;
    localparam int DW = 8;
    localparam int VW = 4;
    localparam int AW = 6;
    localparam int RW = 2*DW + $clog2(VW);
    localparam int MEMSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    num_jobs = '0;
    logic [AW-1:0] base_a = '0;
    logic [AW-1:0] base_b = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          op_valid;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_last;
    logic          dp_valid = 1'b0;
    logic [RW-1:0] dp_result = '0;
    logic          result_valid;
    logic [RW-1:0] dot_product_result;
    logic          processing_done;
    logic          writer_done = 1'b0;
    logic          busy;
    logic          done;
    logic [2:0]    job_count;
    logic          timeout_err;

    dot_product_ctrl #(.DATA_WIDTH(DW), .VECTOR_WIDTH(VW), .ADDR_WIDTH(AW), .RESULT_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_jobs(num_jobs),
        .base_a(base_a), .base_b(base_b), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
        .op_last(op_last), .dp_valid(dp_valid), .dp_result(dp_result),
        .result_valid(result_valid), .dot_product_result(dot_product_result),
        .processing_done(processing_done), .writer_done(writer_done), .busy(busy),
        .done(done), .job_count(job_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ba; int bb; int nj; int dpd; int wrd; int exp_jobs; int exp_rv;
    } vec_t;
    vec_t vt[5];

    int total = 0;
    int bad = 0;
    logic [DW-1:0] mem [0:MEMSZ-1];
    int q_addr[$];
    int q_res[$];
    int rv_cnt = 0, done_cnt = 0, op_cnt = 0, rd_cnt = 0;
    int op_idx = 0;
    bit prev_rv = 1'b0;
    bit dp_enable = 1'b1, wr_enable = 1'b1;
    int dp_delay = 0, wr_delay = 0;
    int dp_acc = 0, dp_wt = 0, wr_wt = 0;
    bit dp_pend = 1'b0, wr_pend = 1'b0;
    int d0, rv0, op0, rd0, n, cnt, last_exp;
    bit ok;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int exp_dot(input int ba, input int bb, input int j);
        int s = 0;
        for (int e = 0; e < VW; e++)
            s += int'(mem[(ba + j*VW + e) % MEMSZ]) * int'(mem[(bb + j*VW + e) % MEMSZ]);
        return s;
    endfunction

    task automatic push_job(input int ba, input int bb, input int j);
        for (int e = 0; e < VW; e++) begin
            q_addr.push_back((ba + j*VW + e) % MEMSZ);
            q_addr.push_back((bb + j*VW + e) % MEMSZ);
        end
    endtask

    task automatic do_start(input int ba, input int bb, input int nj);
        @(negedge clk);
        base_a = AW'(ba); base_b = AW'(bb); num_jobs = 3'(nj); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, output bit found);
        found = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (done) begin found = 1'b1; return; end
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL %s actual=no done pulse required=done pulse", nm);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        dp_delay = v.dpd; wr_delay = v.wrd;
        for (int j = 0; j < v.nj; j++) begin
            push_job(v.ba, v.bb, j);
            last_exp = exp_dot(v.ba, v.bb, j);
            q_res.push_back(last_exp);
        end
        rv0 = rv_cnt; op0 = op_cnt; d0 = done_cnt;
        do_start(v.ba, v.bb, v.nj);
        wait_done(nm, ok);
        if (ok) begin
            chk({nm, "_job_count"}, job_count, v.exp_jobs);
            chk({nm, "_timeout_err"}, timeout_err, 0);
            chk({nm, "_busy_at_done"}, busy, 0);
            @(negedge clk);
            chk({nm, "_rv_count"}, rv_cnt - rv0, v.exp_rv);
            chk({nm, "_op_count"}, op_cnt - op0, v.nj * VW);
            chk({nm, "_done_pulses"}, done_cnt - d0, 1);
            chk({nm, "_done_width"}, done, 0);
            chk({nm, "_addr_left"}, q_addr.size(), 0);
            if (v.nj != 0) chk({nm, "_result_hold"}, dot_product_result, last_exp);
        end else begin
            abort = 1'b1; @(negedge clk); abort = 1'b0;
        end
        q_addr.delete(); q_res.delete();
    endtask

    // Synchronous memory: data valid the cycle after the request.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    initial begin : dp_model
        forever begin
            @(negedge clk);
            dp_valid = 1'b0;
            if (!busy) begin
                dp_acc = 0; dp_pend = 1'b0;
            end else if (dp_pend) begin
                if (dp_wt == 0) begin
                    dp_valid = 1'b1; dp_result = RW'(dp_acc); dp_pend = 1'b0; dp_acc = 0;
                end else dp_wt--;
            end
            if (op_valid) begin
                dp_acc += int'(op_a) * int'(op_b);
                if (op_last) begin dp_pend = dp_enable; dp_wt = dp_delay; end
            end
        end
    end

    initial begin : writer_model
        forever begin
            @(negedge clk);
            writer_done = 1'b0;
            if (!busy) wr_pend = 1'b0;
            else if (wr_pend) begin
                if (wr_wt == 0) begin writer_done = 1'b1; wr_pend = 1'b0; end
                else wr_wt--;
            end
            if (processing_done && wr_enable) begin wr_pend = 1'b1; wr_wt = wr_delay; end
        end
    end

    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_cnt++;
            if (q_addr.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected actual=addr %0d required=no read", mem_rd_addr);
            end else chk("rd_addr", mem_rd_addr, q_addr.pop_front());
        end
        if (op_valid) begin
            op_cnt++;
            chk("op_last", op_last, (op_idx == VW-1) ? 1 : 0);
            op_idx = (op_idx + 1) % VW;
        end
        if (!busy) op_idx = 0;
        if (result_valid) begin
            rv_cnt++;
            if (q_res.size() == 0) begin
                total++; bad++;
                $display("FAIL rv_unexpected actual=%0d required=no result", dot_product_result);
            end else chk("result", dot_product_result, q_res.pop_front());
        end
        if (processing_done) chk("pd_after_rv", prev_rv, 1);
        prev_rv = result_valid;
        if (done) done_cnt++;
    end

    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = DW'((i*29 + 7) % 256);
        for (int i = 0; i < 4; i++) begin mem[i] = DW'(i + 1); mem[8+i] = DW'(1); end
        vt[0] = '{0,  8,  1, 0, 0, 1, 1};
        vt[1] = '{0,  8,  3, 2, 3, 3, 3};
        vt[2] = '{62, 8,  1, 1, 1, 1, 1};
        vt[3] = '{20, 40, 2, 5, 0, 2, 2};
        vt[4] = '{60, 61, 7, 0, 2, 7, 7};

        repeat (3) @(negedge clk);
        chk("reset_strobes", {busy, done, mem_rd_en, op_valid, op_last, result_valid,
                              processing_done, timeout_err}, 0);
        chk("reset_job_count", job_count, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
            if (i == 0) chk("vec0_result_10", dot_product_result, 10);
        end

        // Dot-product unit never answers.
        dp_enable = 1'b0;
        push_job(0, 8, 0);
        rv0 = rv_cnt;
        do_start(0, 8, 2);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            if (op_valid && op_last) ok = 1'b1;
            else @(negedge clk);
        end
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); n++;
            if (timeout_err) break;
        end
        chk("tmo_latency", n, 17);
        chk("tmo_done", done, 1);
        chk("tmo_no_rv", rv_cnt - rv0, 0);
        @(negedge clk);
        chk("tmo_sticky", timeout_err, 1);
        chk("tmo_idle", busy, 0);
        dp_enable = 1'b1;
        q_addr.delete();

        // Abort during RD_B of the second element.
        q_addr.push_back(0); q_addr.push_back(8); q_addr.push_back(1); q_addr.push_back(9);
        d0 = done_cnt;
        do_start(0, 8, 1);
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (mem_rd_en) cnt++;
            if (cnt == 4) break;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_job_count", job_count, 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_addr_left", q_addr.size(), 0);
        q_addr.delete();
        run_vec(vt[1], "post_abort");

        // Zero-job batch.
        d0 = done_cnt; rd0 = rd_cnt;
        do_start(0, 8, 0);
        chk("zero_done", done, 1);
        @(negedge clk);
        chk("zero_no_reads", rd_cnt - rd0, 0);
        chk("zero_busy", busy, 0);

        // Reset while waiting for the writer.
        wr_enable = 1'b0;
        push_job(0, 8, 0);
        q_res.push_back(exp_dot(0, 8, 0));
        do_start(0, 8, 1);
        for (int c = 0; c < 200; c++) begin
            if (processing_done) break;
            @(negedge clk);
        end
        @(negedge clk);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_strobes", {busy, done, mem_rd_en, op_valid, op_last, result_valid,
                                processing_done, timeout_err}, 0);
        chk("rst_mid_result", dot_product_result, 0);
        chk("rst_mid_job_count", job_count, 0);
        chk("rst_mid_op_a", op_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        wr_enable = 1'b1;
        q_addr.delete(); q_res.delete();
        run_vec(vt[0], "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
